// File: rtl/reset_sequencer.sv
// Power-up reset sequencer: waits for stable PLL lock and DDR calibration, then
// releases memory, core and video resets in order; any lock loss reasserts them all.
module reset_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter int unsigned STAGE_GAP   = 16,
    parameter int unsigned CAL_TIMEOUT = 65535
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_locked_i,
    input  logic       mem_calib_done_i,
    output logic       mem_rst_o,
    output logic       core_rst_o,
    output logic       video_rst_o,
    output logic       ready_o,
    output logic       error_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        HOLD      = 3'd1,
        MEM       = 3'd2,
        CORE      = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_t;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(STAGE_GAP - 1);
    localparam logic [15:0] CAL_LAST  = 16'((CAL_TIMEOUT == 0) ? 0 : CAL_TIMEOUT - 1);
    localparam bit          CAL_EN    = (CAL_TIMEOUT != 0);

    logic [SYNC_STAGES-1:0] lock_sync;
    logic [SYNC_STAGES-1:0] cal_sync;
    logic                   lock_s;
    logic                   cal_s;

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [15:0] cnt_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_sync <= '0;
            cal_sync  <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked_i};
            cal_sync  <= {cal_sync[SYNC_STAGES-2:0], mem_calib_done_i};
        end
    end

    assign lock_s = lock_sync[SYNC_STAGES-1];
    assign cal_s  = cal_sync[SYNC_STAGES-1];

    // Lock loss is checked first in every active state so it beats cal/timeout/gap.
    always_comb begin
        state_next = state;
        case (state)
            WAIT_LOCK: if (lock_s) state_next = HOLD;
            HOLD: begin
                if (!lock_s)               state_next = WAIT_LOCK;
                else if (cnt == HOLD_LAST) state_next = MEM;
            end
            MEM: begin
                if (!lock_s)                         state_next = WAIT_LOCK;
                else if (cal_s)                      state_next = CORE;
                else if (CAL_EN && cnt == CAL_LAST)  state_next = FAULT;
            end
            CORE: begin
                if (!lock_s)              state_next = WAIT_LOCK;
                else if (cnt == GAP_LAST) state_next = RUN;
            end
            RUN:     if (!lock_s) state_next = WAIT_LOCK;
            FAULT:   state_next = FAULT;
            default: state_next = WAIT_LOCK;
        endcase
    end

    always_comb begin
        cnt_next = '0;
        if (state_next == state && (state == HOLD || state == MEM || state == CORE))
            cnt_next = cnt + 16'd1;
    end

    // Outputs are decoded from the next state so they change on the same edge as state_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            mem_rst_o   <= 1'b1;
            core_rst_o  <= 1'b1;
            video_rst_o <= 1'b1;
            ready_o     <= 1'b0;
            error_o     <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            mem_rst_o   <= !(state_next inside {MEM, CORE, RUN});
            core_rst_o  <= !(state_next inside {CORE, RUN});
            video_rst_o <= (state_next != RUN);
            ready_o     <= (state_next == RUN);
            error_o     <= error_o | (state_next == FAULT);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues expected output changes
// with their edge numbers, a negedge monitor pops and compares each change it sees.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       pll_locked_i;
    logic       mem_calib_done_i;
    logic       mem_rst_o;
    logic       core_rst_o;
    logic       video_rst_o;
    logic       ready_o;
    logic       error_o;
    logic [2:0] state_o;

    reset_sequencer #(
        .SYNC_STAGES(2),
        .HOLD_CYCLES(8),
        .STAGE_GAP(4),
        .CAL_TIMEOUT(100)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .pll_locked_i(pll_locked_i),
        .mem_calib_done_i(mem_calib_done_i),
        .mem_rst_o(mem_rst_o),
        .core_rst_o(core_rst_o),
        .video_rst_o(video_rst_o),
        .ready_o(ready_o),
        .error_o(error_o),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Snapshot layout: {error, ready, video_rst, core_rst, mem_rst, state[2:0]}
    localparam logic [7:0] O_RST   = 8'h38;
    localparam logic [7:0] O_HOLD  = 8'h39;
    localparam logic [7:0] O_MEM   = 8'h32;
    localparam logic [7:0] O_CORE  = 8'h23;
    localparam logic [7:0] O_RUN   = 8'h44;
    localparam logic [7:0] O_FAULT = 8'hBD;

    typedef struct {
        int unsigned at;
        logic [7:0]  outs;
    } exp_t;

    exp_t        q[$];
    int unsigned edge_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after edge e-1 so an input driven now is first sampled at edge e.
    task automatic drive_at(input int unsigned e);
        while (edge_cnt + 1 < e) tick();
    endtask

    task automatic push(input int unsigned at, input logic [7:0] outs);
        exp_t x;
        x.at   = at;
        x.outs = outs;
        q.push_back(x);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && q.size() != 0; i++) tick();
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_%s: %0d expected events still pending, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic pulse_rst();
        rst_i            = 1'b1;
        pll_locked_i     = 1'b0;
        mem_calib_done_i = 1'b0;
        push(edge_cnt + 1, O_RST);
        tick();
        rst_i = 1'b0;
        repeat (3) tick();
    endtask

    logic [7:0] cur;
    logic [7:0] prev;
    bit         first = 1'b1;
    exp_t       got;

    always @(negedge clk) begin
        cur = {error_o, ready_o, video_rst_o, core_rst_o, mem_rst_o, state_o};
        if (q.size() != 0 && q[0].at < edge_cnt) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missed_event: outputs %h required at edge %0d, not seen by edge %0d",
                     q[0].outs, q[0].at, edge_cnt);
            void'(q.pop_front());
        end
        if (first || cur != prev) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change: outputs %h -> %h at edge %0d, required no change",
                         prev, cur, edge_cnt);
            end else begin
                got = q.pop_front();
                if (got.at != edge_cnt || got.outs != cur) begin
                    n_bad++;
                    $display("FAIL event: got outputs %h at edge %0d, required %h at edge %0d",
                             cur, edge_cnt, got.outs, got.at);
                end
            end
        end
        prev  = cur;
        first = 1'b0;
        n_cmp++;
        if ((!core_rst_o && mem_rst_o) || (!video_rst_o && core_rst_o) ||
            (ready_o != (state_o == 3'd4))) begin
            n_bad++;
            $display("FAIL ordering_invariant: outputs %h at edge %0d violate reset ordering", cur, edge_cnt);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d, required completion", edge_cnt);
        $fatal(1, "watchdog");
    end

    int unsigned b;

    initial begin
        // Reset held 3 cycles with both inputs high
        rst_i            = 1'b1;
        pll_locked_i     = 1'b1;
        mem_calib_done_i = 1'b1;
        push(1, O_RST);
        repeat (3) tick();
        rst_i            = 1'b0;
        pll_locked_i     = 1'b0;
        mem_calib_done_i = 1'b0;
        repeat (5) tick();
        drain("reset");

        // Nominal bring-up, then lock loss in RUN and re-lock
        b = edge_cnt + 1;
        pll_locked_i = 1'b1;
        push(b + 2,  O_HOLD);
        push(b + 10, O_MEM);
        push(b + 22, O_CORE);
        push(b + 26, O_RUN);
        push(b + 52, O_RST);
        push(b + 62, O_HOLD);
        push(b + 70, O_MEM);
        push(b + 71, O_CORE);
        push(b + 75, O_RUN);
        drive_at(b + 20);
        mem_calib_done_i = 1'b1;
        drive_at(b + 50);
        pll_locked_i = 1'b0;
        drive_at(b + 60);
        pll_locked_i = 1'b1;
        drive_at(b + 80);
        drain("nominal");
        pulse_rst();
        drain("rst_after_nominal");

        // One-sample lock dropout during HOLD restarts the count
        b = edge_cnt + 1;
        pll_locked_i = 1'b1;
        push(b + 2,  O_HOLD);
        push(b + 7,  O_RST);
        push(b + 8,  O_HOLD);
        push(b + 16, O_MEM);
        drive_at(b + 5);
        pll_locked_i = 1'b0;
        drive_at(b + 6);
        pll_locked_i = 1'b1;
        drive_at(b + 20);
        drain("hold_glitch");
        pulse_rst();
        drain("rst_after_glitch");

        // Calibration never completes; FAULT must ignore lock toggling
        b = edge_cnt + 1;
        pll_locked_i = 1'b1;
        push(b + 2,   O_HOLD);
        push(b + 10,  O_MEM);
        push(b + 110, O_FAULT);
        drive_at(b + 112);
        pll_locked_i = 1'b0;
        repeat (4) tick();
        pll_locked_i = 1'b1;
        repeat (6) tick();
        drain("timeout");
        pulse_rst();
        drain("rst_after_fault");

        // rst_i pulse while in MEM with both inputs high
        b = edge_cnt + 1;
        pll_locked_i = 1'b1;
        push(b + 2,  O_HOLD);
        push(b + 10, O_MEM);
        drive_at(b + 12);
        mem_calib_done_i = 1'b1;
        drive_at(b + 13);
        rst_i = 1'b1;
        push(b + 13, O_RST);
        push(b + 16, O_HOLD);
        push(b + 24, O_MEM);
        push(b + 25, O_CORE);
        push(b + 29, O_RUN);
        tick();
        rst_i = 1'b0;
        drive_at(b + 35);
        drain("rst_mid_mem");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
